// File: rtl/y86_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory load port, redirect port and the decode-side
// valid/ready bus. slave = fetch queue, master = whoever loads memory and consumes entries.
interface y86_fetch_queue_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 3
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [7:0]        imem_wdata;
  logic              redir_valid;
  logic [63:0]       redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [3:0]        out_icode;
  logic [3:0]        out_ifun;
  logic [3:0]        out_rA;
  logic [3:0]        out_rB;
  logic [63:0]       out_valC;
  logic [63:0]       out_valP;
  logic              out_instr_valid;
  logic              out_imem_error;
  logic              out_hlt;
  logic              fetching;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output imem_we, imem_waddr, imem_wdata, redir_valid, redir_pc, out_ready,
    input  out_valid, out_pc, out_icode, out_ifun, out_rA, out_rB, out_valC,
           out_valP, out_instr_valid, out_imem_error, out_hlt, fetching, q_count
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, redir_valid, redir_pc, out_ready,
    output out_valid, out_pc, out_icode, out_ifun, out_rA, out_rB, out_valC,
           out_valP, out_instr_valid, out_imem_error, out_hlt, fetching, q_count
  );
endinterface

// File: rtl/y86_fetch_queue.sv
// Y86-64 fetch stage with run-time loaded byte memory, one decode per cycle and a
// first-word-fall-through prefetch queue with static taken prediction for jXX/call.
//
// state     | meaning
// S_IDLE    | after reset; no fetch until a redirect
// S_FETCH   | decode at fpc and push one entry per cycle when queue has room
// S_STOPPED | halt/ret/invalid/error entry pushed; wait for a redirect
module y86_fetch_queue #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10,
  parameter int QDEPTH    = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  y86_fetch_queue_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STOPPED} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        err;
    logic        hlt;
  } entry_t;

  localparam logic [63:0]      MEM_END = 64'(MEM_BYTES);
  localparam logic [ADDR_W:0]  MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [CNT_W-1:0] QD      = CNT_W'(QDEPTH);

  logic [7:0]       r_mem [MEM_BYTES];
  state_t           r_state;
  logic [63:0]      r_fpc;
  logic             r_fetching;
  entry_t           r_q [QDEPTH];
  logic [CNT_W-1:0] r_count;

  logic [7:0]       w_b [10];
  logic             w_fpc_in;
  logic [3:0]       w_icode;
  logic             w_legal;
  logic [3:0]       w_len;
  logic [63:0]      w_valp;
  logic             w_err;
  logic             w_stop;
  logic [63:0]      w_nfpc;
  entry_t           w_ent;
  entry_t           w_shift [QDEPTH];
  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_wr_idx;

  always_ff @(posedge clk) begin
    if (bus.imem_we && ({1'b0, bus.imem_waddr} < MEM_LIM))
      r_mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  assign w_fpc_in = (r_fpc < MEM_END);

  // Bytes at or past the end of memory read as zero; fpc < MEM_END rules out wrap.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      w_b[i] = 8'h00;
      if (w_fpc_in && ((r_fpc + 64'(i)) < MEM_END))
        w_b[i] = r_mem[r_fpc[ADDR_W-1:0] + ADDR_W'(i)];
    end
  end

  always_comb begin
    w_icode = w_b[0][7:4];
    w_legal = (w_icode <= 4'hB);
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
      4'h3, 4'h4, 4'h5:       w_len = 4'd10;
      4'h7, 4'h8:             w_len = 4'd9;
      default:                w_len = 4'd1;
    endcase
    w_valp = r_fpc + 64'(w_len);
    w_err  = !w_fpc_in || (w_valp > MEM_END);

    w_ent       = '0;
    w_ent.pc    = r_fpc;
    w_ent.icode = w_legal ? w_icode : 4'h0;
    w_ent.ifun  = w_legal ? w_b[0][3:0] : 4'h0;
    w_ent.ra    = 4'hF;
    w_ent.rb    = 4'hF;
    w_ent.valp  = w_valp;
    w_ent.iv    = w_legal;
    w_ent.err   = w_err;
    w_ent.hlt   = (w_icode == 4'h0) && !w_err;
    if (w_len == 4'd2 || w_len == 4'd10) begin
      w_ent.ra = w_b[1][7:4];
      w_ent.rb = w_b[1][3:0];
    end
    if (w_len == 4'd10)
      w_ent.valc = {w_b[9], w_b[8], w_b[7], w_b[6], w_b[5], w_b[4], w_b[3], w_b[2]};
    else if (w_len == 4'd9)
      w_ent.valc = {w_b[8], w_b[7], w_b[6], w_b[5], w_b[4], w_b[3], w_b[2], w_b[1]};

    w_stop = (w_icode == 4'h0) || (w_icode == 4'h9) || !w_legal || w_err;
    if (w_stop)
      w_nfpc = r_fpc;
    else if (w_icode == 4'h7 || w_icode == 4'h8)
      w_nfpc = w_ent.valc;
    else
      w_nfpc = w_valp;
  end

  assign w_pop    = (r_count != '0) && bus.out_ready;
  assign w_push   = (r_state == S_FETCH) && !bus.redir_valid && ((r_count < QD) || w_pop);
  assign w_wr_idx = w_pop ? (r_count - 1'b1) : r_count;

  always_comb begin
    for (int i = 0; i < QDEPTH - 1; i++)
      w_shift[i] = r_q[i+1];
    w_shift[QDEPTH-1] = r_q[QDEPTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fpc      <= '0;
      r_fetching <= 1'b0;
    end else if (bus.redir_valid) begin
      r_state    <= S_FETCH;
      r_fpc      <= bus.redir_pc;
      r_fetching <= 1'b1;
    end else if (w_push) begin
      r_fpc <= w_nfpc;
      if (w_stop) begin
        r_state    <= S_STOPPED;
        r_fetching <= 1'b0;
      end
    end
  end

  // Shift-register queue: slot 0 is always the head, so outputs come straight from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++)
        r_q[i] <= '0;
    end else if (bus.redir_valid) begin
      r_count <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (w_push && (CNT_W'(i) == w_wr_idx))
          r_q[i] <= w_ent;
        else if (w_pop)
          r_q[i] <= w_shift[i];
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign bus.out_valid       = (r_count != '0);
  assign bus.out_pc          = r_q[0].pc;
  assign bus.out_icode       = r_q[0].icode;
  assign bus.out_ifun        = r_q[0].ifun;
  assign bus.out_rA          = r_q[0].ra;
  assign bus.out_rB          = r_q[0].rb;
  assign bus.out_valC        = r_q[0].valc;
  assign bus.out_valP        = r_q[0].valp;
  assign bus.out_instr_valid = r_q[0].iv;
  assign bus.out_imem_error  = r_q[0].err;
  assign bus.out_hlt         = r_q[0].hlt;
  assign bus.fetching        = r_fetching;
  assign bus.q_count         = r_count;

endmodule

// File: doc/y86_fetch_queue.md
Name: y86_fetch_queue

Overview:
- Parametrised successor to the Y86-64 SEQ fetch stage. Holds a byte-addressed instruction memory that is loaded at run time through a write port, and decodes one instruction per cycle.
- Runs ahead of decode. Decoded entries are pushed into a prefetch queue of QDEPTH entries and delivered to decode through a valid/ready handshake.
- Supports PC redirect and flush, and static next-PC prediction for jXX/call.
- Used by the pipelined core and by SEQ, with QDEPTH=1 for SEQ.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes.
- ADDR_W, 10: memory write address width; must satisfy 2^ADDR_W >= MEM_BYTES.
- QDEPTH, 4: prefetch queue entries, minimum 1.
- CNT_W, 3: width of q_count; must satisfy 2^CNT_W > QDEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_we  in  1  byte write enable.
- imem_waddr  in  ADDR_W  byte write address.
- imem_wdata  in  8  byte write data.
- redir_valid  in  1  redirect request.
- redir_pc  in  64  redirect target PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  64  PC of head instruction.
- out_icode  out  4  head icode.
- out_ifun  out  4  head ifun.
- out_rA  out  4  head rA.
- out_rB  out  4  head rB.
- out_valC  out  64  head valC.
- out_valP  out  64  head fall-through PC.
- out_instr_valid  out  1  icode legal.
- out_imem_error  out  1  fetch ran past memory.
- out_hlt  out  1  halt instruction.
- fetching  out  1  state==FETCH.
- q_count  out  CNT_W  occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch PC fpc=0, queue empty.
  - All out_* fields are 0, out_valid=0, q_count=0.
  - Memory contents are not cleared.
- States:
  - IDLE: no fetch; leaves only on redir_valid.
  - FETCH: pushes one entry per cycle when allowed.
  - STOPPED: entered after pushing a halt, ret, invalid or imem_error entry; no further fetch until redir_valid.
- Redirect:
  - redir_valid high at an edge flushes the queue (q_count=0, out_valid=0), sets fpc=redir_pc and state=FETCH.
  - Redirect overrides any same-cycle push and pop; the popped head is discarded.
  - Legal in every state.
- Push condition: state==FETCH, !redir_valid, and (q_count<QDEPTH or pop this cycle).
- Pop: out_valid & out_ready. A simultaneous push and pop leaves q_count unchanged.
- Latency: redirect at edge k produces the first entry at edge k+1; out_valid is high from edge k+1. The queue is first-word-fall-through; outputs come from the head register.
- Decode of bytes b0..b9 at fpc:
  - icode=b0[7:4], ifun=b0[3:0].
  - Length: halt, nop and ret are 1 byte. cmovXX, OPq, pushq and popq are 2. irmovq, rmmovq and mrmovq are 10. jXX and call are 9.
  - rA/rB = b1[7:4]/b1[3:0] for 2- and 10-byte forms; 4'hF otherwise.
  - valC is little-endian: b2..b9 for 10-byte forms, b1..b8 for 9-byte forms; 0 otherwise.
  - valP = fpc + length (64-bit, wraps).
- Next fpc:
  - jXX (all ifun) and call: valC, i.e. predict taken.
  - halt, ret, invalid or error: unchanged, and state becomes STOPPED.
  - All others: valP.
- Illegal icode (>4'hB): instr_valid=0, valP=fpc+1, other fields 0, rA=rB=F.
- Memory error:
  - Condition: fpc >= MEM_BYTES, or fpc+length-1 >= MEM_BYTES.
  - Entry has imem_error=1. If fpc >= MEM_BYTES, icode=ifun=0, hlt=0, instr_valid=1.
  - Bytes beyond the memory read as 0.
- hlt=1 only for icode 0 without error.
- Memory writes: allowed in any state. A same-cycle read of the written byte returns the old value.

Test Plan:
- Load bytes 30 F4 11 22 33 44 55 66 77 88 at address 0, then 00 at address 10; redirect to 0; out_ready=1.
  - Entry 1: icode=3, rA=F, rB=4, valC=0x8877665544332211, valP=10.
  - Entry 2: hlt=1, pc=10.
  - Then STOPPED, with fetching=0 and no further entries.
- QDEPTH=4, 6 consecutive nops (10), out_ready=0: q_count saturates at 4 and fpc holds at 4. Raise out_ready: entries with pc 0..5 appear in order, one per cycle.
- jXX at address 0 with target 0x20, nop at 0x20: second entry pc=0x20. Redirect to 9 while 2 entries are queued: out_valid=0 next cycle, then pc=9.
- Redirect to 1020 with irmovq at 1020: imem_error=1, icode=3, state STOPPED. Redirect to 2000: entry has imem_error=1, icode=0.
- Byte 0xC0 at address 5, redirect to 5: instr_valid=0, valP=6, STOPPED. Assert rst_n=0 mid-queue: out_valid=0 and q_count=0 immediately, asynchronously.
